mdio_req_arbiter: RTL and testbench

- Sequencer and two-port round-robin arbiter in front of the MDIO transaction generator.
- Accepts Clause 22 register read/write requests from two independent clients (port A, port B) and builds the 32-bit management frame.
- Launches each frame on the generator, tracks it to completion, and returns read data and status to the granted client.
- Sits between the link/PHY management logic and the generator. Exactly one transaction is in flight at a time.

---
 rtl/mdio_req_arbiter_if.sv | 45 ++++
 rtl/mdio_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_mdio_req_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_req_arbiter_if.sv
// Client request/completion and MDIO generator signals shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the client/generator side.
interface mdio_req_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [4:0]  a_phy;
  logic [4:0]  a_reg;
  logic [15:0] a_wdata;
  logic        a_done;
  logic [15:0] a_rdata;
  logic        a_err;

  logic        b_req;
  logic        b_we;
  logic [4:0]  b_phy;
  logic [4:0]  b_reg;
  logic [15:0] b_wdata;
  logic        b_done;
  logic [15:0] b_rdata;
  logic        b_err;

  logic        mdio_start;
  logic [31:0] t_data;
  logic [5:0]  gen_counter;
  logic [15:0] gen_rd_data;
  logic        busy;

  modport slave (
    input  a_req, a_we, a_phy, a_reg, a_wdata,
    output a_done, a_rdata, a_err,
    input  b_req, b_we, b_phy, b_reg, b_wdata,
    output b_done, b_rdata, b_err,
    output mdio_start, t_data, busy,
    input  gen_counter, gen_rd_data
  );

  modport master (
    output a_req, a_we, a_phy, a_reg, a_wdata,
    input  a_done, a_rdata, a_err,
    output b_req, b_we, b_phy, b_reg, b_wdata,
    input  b_done, b_rdata, b_err,
    input  mdio_start, t_data, busy,
    output gen_counter, gen_rd_data
  );
endinterface

// File: rtl/mdio_req_arbiter.sv
// Two-port round-robin arbiter and sequencer for Clause 22 MDIO frames: builds the frame,
// launches it on the generator, watches it finish (or time out) and reports back to the client.
module mdio_req_arbiter #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd200,
  parameter logic [3:0] GAP_CYC     = 4'd2
) (
  input  logic              clk,
  input  logic              reset,
  mdio_req_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_BUSY, S_DONE, S_GAP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;
  logic        r_gnt;
  logic        r_we;
  logic [7:0]  r_tcnt;
  logic [3:0]  r_gap;
  logic [31:0] r_tdata;
  logic        r_a_done;
  logic        r_b_done;
  logic        r_a_err;
  logic        r_b_err;
  logic [15:0] r_a_rdata;
  logic [15:0] r_b_rdata;

  logic        w_anyReq;
  logic        w_pickB;
  logic        w_pickWe;
  logic [4:0]  w_phy;
  logic [4:0]  w_reg;
  logic [15:0] w_wdata;
  logic [31:0] w_frame;
  logic        w_timeout;
  logic        w_finish;
  logic        w_finErr;

  // Pointer breaks ties only; a lone requester always wins.
  assign w_anyReq  = bus.a_req | bus.b_req;
  assign w_pickB   = bus.b_req & (~bus.a_req | r_ptr);
  assign w_pickWe  = w_pickB ? bus.b_we    : bus.a_we;
  assign w_phy     = w_pickB ? bus.b_phy   : bus.a_phy;
  assign w_reg     = w_pickB ? bus.b_reg   : bus.a_reg;
  assign w_wdata   = w_pickB ? bus.b_wdata : bus.a_wdata;
  assign w_frame   = w_pickWe ? {2'b01, 2'b01, w_phy, w_reg, 2'b10, w_wdata}
                              : {2'b01, 2'b10, w_phy, w_reg, 2'b00, 16'h0000};
  assign w_timeout = (r_tcnt >= TIMEOUT_CYC);

  assign bus.mdio_start = (r_state == S_ARM);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.t_data     = r_tdata;
  assign bus.a_done     = r_a_done;
  assign bus.b_done     = r_b_done;
  assign bus.a_err      = r_a_err;
  assign bus.b_err      = r_b_err;
  assign bus.a_rdata    = r_a_rdata;
  assign bus.b_rdata    = r_b_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A generator that has already started wins over a timeout landing on the same cycle.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    w_finErr = 1'b0;
    case (r_state)
      S_IDLE: if (w_anyReq) w_next = S_ARM;
      S_ARM: begin
        if (bus.gen_counter != 6'd0) begin
          w_next = S_BUSY;
        end else if (w_timeout) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
          w_finErr = 1'b1;
        end
      end
      S_BUSY: begin
        if (bus.gen_counter == 6'd0) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
        end else if (w_timeout) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
          w_finErr = 1'b1;
        end
      end
      S_DONE: w_next = S_GAP;
      S_GAP:  if (r_gap == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= 1'b0;
      r_gnt     <= 1'b0;
      r_we      <= 1'b0;
      r_tcnt    <= 8'd0;
      r_gap     <= 4'd0;
      r_tdata   <= 32'd0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
      r_a_rdata <= 16'd0;
      r_b_rdata <= 16'd0;
    end else begin
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_tdata <= w_frame;
            r_gnt   <= w_pickB;
            r_we    <= w_pickWe;
            r_tcnt  <= 8'd0;
            r_ptr   <= ~w_pickB;
          end
        end
        S_ARM, S_BUSY: begin
          if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
          // Done is raised on entry to DONE so it is high for exactly the DONE cycle.
          if (w_finish) begin
            if (!r_gnt) begin
              r_a_done <= 1'b1;
              r_a_err  <= w_finErr;
              if (!r_we && !w_finErr) r_a_rdata <= bus.gen_rd_data;
            end else begin
              r_b_done <= 1'b1;
              r_b_err  <= w_finErr;
              if (!r_we && !w_finErr) r_b_rdata <= bus.gen_rd_data;
            end
          end
        end
        S_DONE: r_gap <= GAP_CYC;
        S_GAP: begin
          if (r_gap == 4'd0) r_tdata <= 32'd0;
          else               r_gap   <= r_gap - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// Directed bench for mdio_req_arbiter with a small MDIO generator model that counts 32 bits
// after seeing mdio_start and presents read data when its counter returns to zero.
module tb_mdio_req_arbiter;

   localparam int GAP_CYC = 2;

   logic clk;
   logic reset;
   logic genEnable;
   logic genActive;
   logic [15:0] genRdValue;
   int totalCnt;
   int badCnt;

   mdio_req_arbiter_if mdioBus();

   mdio_req_arbiter #(
      .TIMEOUT_CYC(8'd200),
      .GAP_CYC(4'd2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(mdioBus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Generator model: starts a 32-bit frame when it sees mdio_start, returns read data at the end.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mdioBus.gen_counter <= 6'd0;
         mdioBus.gen_rd_data <= 16'h0000;
         genActive <= 1'b0;
      end else if (genActive) begin
         mdioBus.gen_counter <= mdioBus.gen_counter - 6'd1;
         if (mdioBus.gen_counter == 6'd1) begin
            genActive <= 1'b0;
            mdioBus.gen_rd_data <= genRdValue;
         end
      end else if (genEnable && mdioBus.mdio_start) begin
         genActive <= 1'b1;
         mdioBus.gen_counter <= 6'd32;
      end
   end

   // Last-resort guard so the run can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired got=running want=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Drives one client's request fields.
   task automatic applyStimulus(input bit isB, input bit req, input bit we,
                                input logic [4:0] phy, input logic [4:0] regAddr,
                                input logic [15:0] wdata);
      if (!isB) begin
         mdioBus.a_req = req; mdioBus.a_we = we; mdioBus.a_phy = phy;
         mdioBus.a_reg = regAddr; mdioBus.a_wdata = wdata;
      end else begin
         mdioBus.b_req = req; mdioBus.b_we = we; mdioBus.b_phy = phy;
         mdioBus.b_reg = regAddr; mdioBus.b_wdata = wdata;
      end
   endtask

   // Waits (bounded) for a done pulse, recording latency, launch gap and launched frame.
   task automatic waitForDone(input int maxCyc, output bit gotA, output bit gotB, output int cyc,
                              output int preIdle, output int startCnt, output logic [31:0] frame);
      bit seenStart;
      seenStart = 1'b0;
      gotA = 1'b0; gotB = 1'b0; cyc = 0; preIdle = -1; startCnt = 0; frame = 32'h0;
      while (!gotA && !gotB && cyc < maxCyc) begin
         @(negedge clk);
         cyc++;
         if (mdioBus.mdio_start === 1'b1) begin
            if (!seenStart) begin
               preIdle = cyc - 1;
               frame = mdioBus.t_data;
            end
            seenStart = 1'b1;
            startCnt++;
         end
         gotA = (mdioBus.a_done === 1'b1);
         gotB = (mdioBus.b_done === 1'b1);
      end
   endtask

   // Waits (bounded) for the arbiter to return to idle.
   task automatic waitIdle(input int maxCyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCyc && !ok; i++) begin
         @(negedge clk);
         ok = (mdioBus.busy === 1'b0);
      end
   endtask

   // Outputs are all zero in reset and the block is idle after release.
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      totalCnt++;
      if ({mdioBus.mdio_start, mdioBus.busy, mdioBus.a_done, mdioBus.b_done, mdioBus.a_err, mdioBus.b_err} !== 6'b0) begin
         badCnt++;
         $display("[TB] FAIL reset_flags got=%b want=000000", {mdioBus.mdio_start, mdioBus.busy, mdioBus.a_done, mdioBus.b_done, mdioBus.a_err, mdioBus.b_err});
      end
      totalCnt++;
      if (mdioBus.t_data !== 32'h0) begin
         badCnt++; $display("[TB] FAIL reset_t_data got=%h want=00000000", mdioBus.t_data);
      end
      totalCnt++;
      if ({mdioBus.a_rdata, mdioBus.b_rdata} !== 32'h0) begin
         badCnt++; $display("[TB] FAIL reset_rdata got=%h want=00000000", {mdioBus.a_rdata, mdioBus.b_rdata});
      end
      reset = 1'b1;
      @(negedge clk);
      totalCnt++;
      if (mdioBus.busy !== 1'b0) begin
         badCnt++; $display("[TB] FAIL reset_release_busy got=%b want=0", mdioBus.busy);
      end
   endtask

   // Port A write: frame, start length, latency, completion.
   task automatic test_write_a();
      bit gotA, gotB, ok; int cyc, preIdle, startCnt; logic [31:0] frame;
      applyStimulus(1'b0, 1'b1, 1'b1, 5'h03, 5'h1F, 16'hBEEF);
      waitForDone(100, gotA, gotB, cyc, preIdle, startCnt, frame);
      totalCnt++;
      if ({gotA, gotB} !== 2'b10) begin
         badCnt++; $display("[TB] FAIL wr_a_grant got=%b want=10", {gotA, gotB});
      end
      totalCnt++;
      if (frame !== 32'h51FEBEEF) begin
         badCnt++; $display("[TB] FAIL wr_a_frame got=%h want=51FEBEEF", frame);
      end
      totalCnt++;
      if (startCnt !== 2) begin
         badCnt++; $display("[TB] FAIL wr_a_start_cycles got=%0d want=2", startCnt);
      end
      totalCnt++;
      if (cyc !== 35) begin
         badCnt++; $display("[TB] FAIL wr_a_latency got=%0d want=35", cyc);
      end
      totalCnt++;
      if ({mdioBus.a_err, mdioBus.a_rdata} !== 17'h0) begin
         badCnt++; $display("[TB] FAIL wr_a_err_rdata got=%h want=00000", {mdioBus.a_err, mdioBus.a_rdata});
      end
      totalCnt++;
      if ({mdioBus.b_done, mdioBus.b_err, mdioBus.b_rdata} !== 18'h0) begin
         badCnt++; $display("[TB] FAIL wr_a_b_isolation got=%h want=00000", {mdioBus.b_done, mdioBus.b_err, mdioBus.b_rdata});
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 5'h03, 5'h1F, 16'hBEEF);
      @(negedge clk);
      totalCnt++;
      if (mdioBus.a_done !== 1'b0) begin
         badCnt++; $display("[TB] FAIL wr_a_done_pulse got=%b want=0", mdioBus.a_done);
      end
      waitIdle(20, ok);
      totalCnt++;
      if (!ok || mdioBus.t_data !== 32'h0) begin
         badCnt++; $display("[TB] FAIL wr_a_idle_clear got=%b/%h want=1/00000000", ok, mdioBus.t_data);
      end
   endtask

   // Port B read returns generator data; port A outputs untouched.
   task automatic test_read_b();
      bit gotA, gotB, ok; int cyc, preIdle, startCnt; logic [31:0] frame;
      genRdValue = 16'h1234;
      applyStimulus(1'b1, 1'b1, 1'b0, 5'h01, 5'h02, 16'h0000);
      waitForDone(100, gotA, gotB, cyc, preIdle, startCnt, frame);
      totalCnt++;
      if ({gotA, gotB} !== 2'b01) begin
         badCnt++; $display("[TB] FAIL rd_b_grant got=%b want=01", {gotA, gotB});
      end
      totalCnt++;
      if (frame !== 32'h60880000) begin
         badCnt++; $display("[TB] FAIL rd_b_frame got=%h want=60880000", frame);
      end
      totalCnt++;
      if ({mdioBus.b_err, mdioBus.b_rdata} !== {1'b0, 16'h1234}) begin
         badCnt++; $display("[TB] FAIL rd_b_rdata got=%h want=01234", {mdioBus.b_err, mdioBus.b_rdata});
      end
      totalCnt++;
      if ({mdioBus.a_done, mdioBus.a_err, mdioBus.a_rdata} !== 18'h0) begin
         badCnt++; $display("[TB] FAIL rd_b_a_isolation got=%h want=00000", {mdioBus.a_done, mdioBus.a_err, mdioBus.a_rdata});
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'h01, 5'h02, 16'h0000);
      waitIdle(20, ok);
      totalCnt++;
      if (!ok) begin
         badCnt++; $display("[TB] FAIL rd_b_idle got=busy want=idle");
      end
   endtask

   // Simultaneous requests from reset alternate A, B, A, B with a gap between launches.
   task automatic test_round_robin();
      bit gotA, gotB, ok; int cyc, preIdle, startCnt; logic [31:0] frame;
      logic [1:0] expGrant; logic [31:0] expFrame;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      genRdValue = 16'hCAFE;
      applyStimulus(1'b0, 1'b1, 1'b1, 5'h04, 5'h05, 16'h1111);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'h06, 5'h07, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         expGrant = (i % 2 == 0) ? 2'b10 : 2'b01;
         expFrame = (i % 2 == 0) ? 32'h52161111 : 32'h631C0000;
         waitForDone(100, gotA, gotB, cyc, preIdle, startCnt, frame);
         totalCnt++;
         if ({gotA, gotB} !== expGrant) begin
            badCnt++; $display("[TB] FAIL rr_grant_%0d got=%b want=%b", i, {gotA, gotB}, expGrant);
         end
         totalCnt++;
         if (frame !== expFrame) begin
            badCnt++; $display("[TB] FAIL rr_frame_%0d got=%h want=%h", i, frame, expFrame);
         end
         if (i > 0) begin
            totalCnt++;
            if (preIdle < GAP_CYC) begin
               badCnt++; $display("[TB] FAIL rr_gap_%0d got=%0d want>=%0d", i, preIdle, GAP_CYC);
            end
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 5'h04, 5'h05, 16'h1111);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'h06, 5'h07, 16'h0000);
      waitIdle(20, ok);
      totalCnt++;
      if (!ok || {mdioBus.a_rdata, mdioBus.b_rdata} !== 32'h0000CAFE) begin
         badCnt++; $display("[TB] FAIL rr_rdata got=%b/%h want=1/0000CAFE", ok, {mdioBus.a_rdata, mdioBus.b_rdata});
      end
   endtask

   // A stuck generator makes the transaction time out; the next one still works.
   task automatic test_timeout();
      bit gotA, gotB, ok; int cyc, preIdle, startCnt; logic [31:0] frame;
      genEnable = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 5'h02, 5'h03, 16'h0000);
      waitForDone(300, gotA, gotB, cyc, preIdle, startCnt, frame);
      totalCnt++;
      if ({gotA, gotB} !== 2'b10) begin
         badCnt++; $display("[TB] FAIL to_grant got=%b want=10", {gotA, gotB});
      end
      totalCnt++;
      if (cyc < 200 || cyc > 202) begin
         badCnt++; $display("[TB] FAIL to_latency got=%0d want=200..202", cyc);
      end
      totalCnt++;
      if ({mdioBus.a_err, mdioBus.a_rdata} !== {1'b1, 16'h0000}) begin
         badCnt++; $display("[TB] FAIL to_err_rdata got=%h want=10000", {mdioBus.a_err, mdioBus.a_rdata});
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 5'h02, 5'h03, 16'h0000);
      waitIdle(20, ok);
      genEnable = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 5'h01, 5'h00, 16'h00FF);
      waitForDone(100, gotA, gotB, cyc, preIdle, startCnt, frame);
      totalCnt++;
      if ({gotA, gotB, mdioBus.b_err, mdioBus.a_err} !== 4'b0101) begin
         badCnt++; $display("[TB] FAIL to_recover got=%b want=0101", {gotA, gotB, mdioBus.b_err, mdioBus.a_err});
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 5'h01, 5'h00, 16'h00FF);
      waitIdle(20, ok);
   endtask

   // Reset between clock edges during BUSY clears outputs at once and issues no done.
   task automatic test_reset_mid();
      int doneSeen;
      genRdValue = 16'h5555;
      applyStimulus(1'b1, 1'b1, 1'b0, 5'h01, 5'h01, 16'h0000);
      repeat (10) @(negedge clk);
      totalCnt++;
      if (mdioBus.busy !== 1'b1 || mdioBus.mdio_start !== 1'b0) begin
         badCnt++; $display("[TB] FAIL rm_in_busy got=%b%b want=10", mdioBus.busy, mdioBus.mdio_start);
      end
      #2;
      reset = 1'b0;
      #1;
      totalCnt++;
      if ({mdioBus.mdio_start, mdioBus.busy, mdioBus.a_done, mdioBus.b_done, mdioBus.a_err, mdioBus.b_err} !== 6'b0) begin
         badCnt++; $display("[TB] FAIL rm_flags got=%b want=000000", {mdioBus.mdio_start, mdioBus.busy, mdioBus.a_done, mdioBus.b_done, mdioBus.a_err, mdioBus.b_err});
      end
      totalCnt++;
      if ({mdioBus.t_data, mdioBus.a_rdata, mdioBus.b_rdata} !== 64'h0) begin
         badCnt++; $display("[TB] FAIL rm_data got=%h want=0", {mdioBus.t_data, mdioBus.a_rdata, mdioBus.b_rdata});
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'h01, 5'h01, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mdioBus.a_done === 1'b1 || mdioBus.b_done === 1'b1) doneSeen++;
      end
      totalCnt++;
      if (doneSeen !== 0 || mdioBus.busy !== 1'b0) begin
         badCnt++; $display("[TB] FAIL rm_after_release got=%0d/%b want=0/0", doneSeen, mdioBus.busy);
      end
   endtask

   // Request held past done launches a second identical frame after the gap.
   task automatic test_back_to_back();
      bit gotA, gotB, ok; int cyc, preIdle, startCnt; logic [31:0] frame;
      applyStimulus(1'b0, 1'b1, 1'b1, 5'h10, 5'h1F, 16'hBEEF);
      waitForDone(100, gotA, gotB, cyc, preIdle, startCnt, frame);
      totalCnt++;
      if ({gotA, gotB} !== 2'b10 || frame !== 32'h587EBEEF) begin
         badCnt++; $display("[TB] FAIL b2b_first got=%b/%h want=10/587EBEEF", {gotA, gotB}, frame);
      end
      waitForDone(100, gotA, gotB, cyc, preIdle, startCnt, frame);
      totalCnt++;
      if ({gotA, gotB} !== 2'b10 || frame !== 32'h587EBEEF) begin
         badCnt++; $display("[TB] FAIL b2b_second got=%b/%h want=10/587EBEEF", {gotA, gotB}, frame);
      end
      totalCnt++;
      if (preIdle < GAP_CYC) begin
         badCnt++; $display("[TB] FAIL b2b_gap got=%0d want>=%0d", preIdle, GAP_CYC);
      end
      totalCnt++;
      if (cyc - preIdle !== 35 || startCnt !== 2) begin
         badCnt++; $display("[TB] FAIL b2b_latency got=%0d/%0d want=35/2", cyc - preIdle, startCnt);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 5'h10, 5'h1F, 16'hBEEF);
      @(negedge clk);
      totalCnt++;
      if (mdioBus.a_done !== 1'b0 || mdioBus.a_err !== 1'b0) begin
         badCnt++; $display("[TB] FAIL b2b_done_drop got=%b%b want=00", mdioBus.a_done, mdioBus.a_err);
      end
      waitIdle(20, ok);
   endtask

   // Scenario sequence and summary.
   initial begin
      totalCnt = 0;
      badCnt = 0;
      reset = 1'b0;
      genEnable = 1'b1;
      genRdValue = 16'h0000;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 16'h0000);
      test_reset();
      test_write_a();
      test_read_b();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
